// File: rtl/eth_rx_fcs_check_if.sv
// Bus bundle for the Ethernet receive FCS checker: PHY-side receive byte
// stream in, payload byte stream plus end-of-frame status out.
interface eth_rx_fcs_check_if;
  // PHY receive side
  logic        rx_dv;
  logic        rx_er;
  logic [7:0]  rx_data;

  // Payload stream towards the packet parser
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        out_eof;

  // End-of-frame status
  logic        frame_done;
  logic        frame_good;
  logic        crc_err;
  logic        len_err;
  logic        phy_err;
  logic [15:0] frame_len;

  // Source of receive bytes, consumer of payload and status
  modport master (
    output rx_dv, rx_er, rx_data,
    input  out_valid, out_data, out_sof, out_eof,
    input  frame_done, frame_good, crc_err, len_err, phy_err, frame_len
  );

  // The checker itself
  modport slave (
    input  rx_dv, rx_er, rx_data,
    output out_valid, out_data, out_sof, out_eof,
    output frame_done, frame_good, crc_err, len_err, phy_err, frame_len
  );
endinterface

// File: rtl/eth_rx_fcs_check.sv
// Receive-side Ethernet frame checker. Finds preamble/SFD, runs the
// reflected CRC-32 over DA..FCS, holds back the last four bytes in a
// five-byte delay line so the FCS is never forwarded, and reports
// CRC / length / PHY-error status in a one-cycle strobe at end of frame.
module eth_rx_fcs_check #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic              clk,
  input  logic              rst,
  eth_rx_fcs_check_if.slave bus
);

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [15:0] MIN_LEN_W   = 16'(MIN_LEN);
  localparam logic [15:0] MAX_LEN_W   = 16'(MAX_LEN);
  localparam logic [7:0]  PRE_BYTE    = 8'h55;
  localparam logic [7:0]  SFD_BYTE    = 8'hD5;
  localparam int          DLY_DEPTH   = 5;
  localparam logic [2:0]  DLY_FULL    = 3'(DLY_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_FRAME,
    ST_DROP
  } state_e;

  // Byte-wide update of the LSB-first CRC register.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    // NOTE: blocking assignments are right here: each bit step must see the
    // result of the previous one within the same evaluation.
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  state_e      state_q;
  logic [31:0] crc_q;
  logic [15:0] len_q;
  logic        phy_seen_q;
  logic [7:0]  dly_q [DLY_DEPTH];
  logic [2:0]  dly_cnt_q;
  logic        first_q;

  logic        out_valid_q;
  logic [7:0]  out_data_q;
  logic        out_sof_q;
  logic        out_eof_q;
  logic        frame_done_q;
  logic        frame_good_q;
  logic        crc_err_q;
  logic        len_err_q;
  logic        phy_err_q;
  logic [15:0] frame_len_q;

  logic [31:0] crc_d;
  logic [15:0] len_d;
  logic        crc_bad;
  logic        len_bad;

  // Next CRC / saturating length for the byte on the bus, and the frame
  // verdicts computed from the registers that hold the whole frame so far.
  always_comb begin
    // NOTE: every signal gets a value on every path so no latch is inferred.
    crc_d   = crc32_byte(crc_q, bus.rx_data);
    len_d   = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
    crc_bad = (crc_q != CRC_RESIDUE);
    len_bad = (len_q < MIN_LEN_W) || (len_q > MAX_LEN_W);
  end

  // Frame FSM with delay line, CRC, length and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      crc_q        <= '0;
      len_q        <= '0;
      phy_seen_q   <= 1'b0;
      dly_cnt_q    <= '0;
      first_q      <= 1'b0;
      // NOTE: the delay line is cleared on reset so a frame aborted by reset
      // can never leave bytes behind that look like payload.
      for (int i = 0; i < DLY_DEPTH; i++) dly_q[i] <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sof_q    <= 1'b0;
      out_eof_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_good_q <= 1'b0;
      crc_err_q    <= 1'b0;
      len_err_q    <= 1'b0;
      phy_err_q    <= 1'b0;
      frame_len_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here updates from
      // the values that were present before the edge.
      // Strobes and status default low; only the cases below raise them.
      out_valid_q  <= 1'b0;
      out_sof_q    <= 1'b0;
      out_eof_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_good_q <= 1'b0;
      crc_err_q    <= 1'b0;
      len_err_q    <= 1'b0;
      phy_err_q    <= 1'b0;
      frame_len_q  <= '0;

      unique case (state_q)
        ST_IDLE: begin
          if (bus.rx_dv) begin
            state_q <= (bus.rx_data == PRE_BYTE) ? ST_PREAMBLE : ST_DROP;
          end
        end

        ST_PREAMBLE: begin
          if (!bus.rx_dv) begin
            state_q <= ST_IDLE;
          end else if (bus.rx_data == SFD_BYTE) begin
            state_q    <= ST_FRAME;
            crc_q      <= CRC_INIT;
            len_q      <= '0;
            phy_seen_q <= 1'b0;
            dly_cnt_q  <= '0;
            first_q    <= 1'b1;
          end else if (bus.rx_data != PRE_BYTE) begin
            state_q <= ST_DROP;
          end
        end

        ST_FRAME: begin
          if (bus.rx_dv) begin
            crc_q <= crc_d;
            len_q <= len_d;
            if (bus.rx_er) phy_seen_q <= 1'b1;
            dly_q[0] <= bus.rx_data;
            for (int i = 1; i < DLY_DEPTH; i++) dly_q[i] <= dly_q[i-1];
            // Oldest byte leaves only once five newer ones exist, which keeps
            // the four FCS bytes inside the line when the frame ends.
            if (dly_cnt_q == DLY_FULL) begin
              out_valid_q <= 1'b1;
              out_data_q  <= dly_q[DLY_DEPTH-1];
              out_sof_q   <= first_q;
              first_q     <= 1'b0;
            end else begin
              dly_cnt_q <= dly_cnt_q + 3'd1;
            end
          end else begin
            // End of frame: flush the last payload byte and report status.
            state_q      <= ST_IDLE;
            frame_done_q <= 1'b1;
            frame_len_q  <= len_q;
            crc_err_q    <= crc_bad;
            len_err_q    <= len_bad;
            phy_err_q    <= phy_seen_q;
            frame_good_q <= !crc_bad && !len_bad && !phy_seen_q;
            if (dly_cnt_q == DLY_FULL) begin
              out_valid_q <= 1'b1;
              out_data_q  <= dly_q[DLY_DEPTH-1];
              out_sof_q   <= first_q;
              out_eof_q   <= 1'b1;
            end
            dly_cnt_q <= '0;
            first_q   <= 1'b0;
          end
        end

        ST_DROP: begin
          if (!bus.rx_dv) state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_sof    = out_sof_q;
  assign bus.out_eof    = out_eof_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_good = frame_good_q;
  assign bus.crc_err    = crc_err_q;
  assign bus.len_err    = len_err_q;
  assign bus.phy_err    = phy_err_q;
  assign bus.frame_len  = frame_len_q;

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Scoreboard bench for eth_rx_fcs_check. Two instances share one receive
// stream: one with default length limits, one with MIN_LEN=8. Expected
// payload and status come from a frame-level model (byte queue plus a
// bit-serial CRC) and are checked by an independent monitor.
module tb_eth_rx_fcs_check;

  localparam logic [31:0] POLY  = 32'hEDB88320;
  localparam logic [31:0] MAGIC = 32'hDEBB20E3;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_dv;
  logic       rx_er;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  eth_rx_fcs_check_if bus_a ();
  eth_rx_fcs_check_if bus_b ();

  assign bus_a.rx_dv   = rx_dv;
  assign bus_a.rx_er   = rx_er;
  assign bus_a.rx_data = rx_data;
  assign bus_b.rx_dv   = rx_dv;
  assign bus_b.rx_er   = rx_er;
  assign bus_b.rx_data = rx_data;

  eth_rx_fcs_check dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  eth_rx_fcs_check #(.MIN_LEN(8), .MAX_LEN(1518)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct {
    logic [7:0] data;
    bit         sof;
    bit         eof;
  } pay_t;

  typedef struct {
    logic [15:0] len;
    bit          crc_err;
    bit          phy_err;
    bit          len_err_a;
    bit          len_err_b;
  } stat_t;

  pay_t       pay_q[$];
  stat_t      stat_q[$];
  logic [7:0] cur_frame[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // CRC register after the first 'upto' bytes of cur_frame, one bit at a time.
  function automatic logic [31:0] crc_reg(input int upto);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int k = 0; k < upto; k++) begin
      for (int b = 0; b < 8; b++) begin
        logic fb;
        fb = c[0] ^ cur_frame[k][b];
        c  = c >> 1;
        if (fb) c = c ^ POLY;
      end
    end
    return c;
  endfunction

  // Random frame of n bytes (DA..FCS); correct FCS unless good_fcs is 0.
  task automatic build_random(input int n, input bit good_fcs);
    logic [31:0] fcs;
    logic [7:0]  m;
    int          idx;
    cur_frame.delete();
    if (n < 4) begin
      for (int i = 0; i < n; i++) cur_frame.push_back(8'($urandom));
    end else begin
      for (int i = 0; i < n - 4; i++) cur_frame.push_back(8'($urandom));
      fcs = ~crc_reg(n - 4);
      for (int i = 0; i < 4; i++) cur_frame.push_back(fcs[8*i +: 8]);
      if (!good_fcs) begin
        idx = n - 1 - int'($urandom_range(3, 0));
        m   = 8'd1 << $urandom_range(7, 0);
        cur_frame[idx] = cur_frame[idx] ^ m;
      end
    end
  endtask

  task automatic push_expect(input int er_at);
    int    n;
    stat_t s;
    n = cur_frame.size();
    if (n >= 5) begin
      for (int k = 0; k <= n - 5; k++) begin
        pay_t p;
        p.data = cur_frame[k];
        p.sof  = (k == 0);
        p.eof  = (k == n - 5);
        pay_q.push_back(p);
      end
    end
    s.len       = 16'(n);
    s.crc_err   = (crc_reg(n) != MAGIC);
    s.phy_err   = (er_at >= 0) && (er_at < n);
    s.len_err_a = (n < 64) || (n > 1518);
    s.len_err_b = (n < 8)  || (n > 1518);
    stat_q.push_back(s);
  endtask

  task automatic drive(input bit dv, input bit er, input logic [7:0] d);
    @(posedge clk);
    #1;
    rx_dv   = dv;
    rx_er   = er;
    rx_data = d;
  endtask

  // Preamble, SFD, cur_frame, then a single idle cycle.
  task automatic send_frame(input int pre_len, input int er_at);
    push_expect(er_at);
    repeat (pre_len) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    foreach (cur_frame[i]) drive(1'b1, (i == er_at), cur_frame[i]);
    drive(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_a"}, 32'({bus_a.out_valid, bus_a.out_sof, bus_a.out_eof, bus_a.frame_done,
                             bus_a.frame_good, bus_a.crc_err, bus_a.len_err, bus_a.phy_err}), 0);
    check({name, "_a_len"}, 32'(bus_a.frame_len), 0);
    check({name, "_b"}, 32'({bus_b.out_valid, bus_b.out_sof, bus_b.out_eof, bus_b.frame_done,
                             bus_b.frame_good, bus_b.crc_err, bus_b.len_err, bus_b.phy_err}), 0);
    check({name, "_b_len"}, 32'(bus_b.frame_len), 0);
  endtask

  // Monitor: pops expectations whenever either instance presents output.
  always @(negedge clk) begin
    if (bus_a.out_valid || bus_b.out_valid) begin
      if (pay_q.size() == 0) begin
        check("spurious_out_valid", 32'({bus_a.out_valid, bus_b.out_valid}), 0);
      end else begin
        pay_t p;
        p = pay_q.pop_front();
        check("out_valid_a", 32'(bus_a.out_valid), 1);
        check("out_valid_b", 32'(bus_b.out_valid), 1);
        check("out_data_a",  32'(bus_a.out_data), 32'(p.data));
        check("out_data_b",  32'(bus_b.out_data), 32'(p.data));
        check("out_sof_a",   32'(bus_a.out_sof), 32'(p.sof));
        check("out_sof_b",   32'(bus_b.out_sof), 32'(p.sof));
        check("out_eof_a",   32'(bus_a.out_eof), 32'(p.eof));
        check("out_eof_b",   32'(bus_b.out_eof), 32'(p.eof));
      end
    end
    if (bus_a.frame_done || bus_b.frame_done) begin
      if (stat_q.size() == 0) begin
        check("spurious_frame_done", 32'({bus_a.frame_done, bus_b.frame_done}), 0);
      end else begin
        stat_t s;
        s = stat_q.pop_front();
        check("frame_done_a", 32'(bus_a.frame_done), 1);
        check("frame_done_b", 32'(bus_b.frame_done), 1);
        check("frame_len_a",  32'(bus_a.frame_len), 32'(s.len));
        check("frame_len_b",  32'(bus_b.frame_len), 32'(s.len));
        check("crc_err_a",    32'(bus_a.crc_err), 32'(s.crc_err));
        check("crc_err_b",    32'(bus_b.crc_err), 32'(s.crc_err));
        check("phy_err_a",    32'(bus_a.phy_err), 32'(s.phy_err));
        check("phy_err_b",    32'(bus_b.phy_err), 32'(s.phy_err));
        check("len_err_a",    32'(bus_a.len_err), 32'(s.len_err_a));
        check("len_err_b",    32'(bus_b.len_err), 32'(s.len_err_b));
        check("frame_good_a", 32'(bus_a.frame_good),
              32'(!(s.crc_err || s.phy_err || s.len_err_a)));
        check("frame_good_b", 32'(bus_b.frame_good),
              32'(!(s.crc_err || s.phy_err || s.len_err_b)));
      end
    end else begin
      check("status_idle_a", 32'({bus_a.frame_good, bus_a.crc_err, bus_a.len_err,
                                  bus_a.phy_err, bus_a.frame_len}), 0);
      check("status_idle_b", 32'({bus_b.frame_good, bus_b.crc_err, bus_b.len_err,
                                  bus_b.phy_err, bus_b.frame_len}), 0);
    end
  end

  initial begin
    rst     = 1'b1;
    rx_dv   = 1'b0;
    rx_er   = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Known vector "123456789" with its FCS, then with the last FCS byte bad.
    for (int pass = 0; pass < 2; pass++) begin
      cur_frame.delete();
      for (int i = 0; i < 9; i++) cur_frame.push_back(8'h31 + 8'(i));
      cur_frame.push_back(8'h26);
      cur_frame.push_back(8'h39);
      cur_frame.push_back(8'hF4);
      cur_frame.push_back((pass == 0) ? 8'hCB : 8'hCA);
      send_frame(7, -1);
    end

    // Length boundaries against the default limits.
    build_random(63, 1);   send_frame(7, -1);
    build_random(64, 1);   send_frame(7, -1);
    build_random(1518, 1); send_frame(7, -1);
    build_random(1519, 1); send_frame(7, -1);

    // Very short frames: no payload up to four bytes, one byte at five.
    build_random(3, 1); send_frame(2, -1);
    build_random(4, 1); send_frame(2, -1);
    build_random(5, 1); send_frame(2, -1);

    // Broken preamble drops the burst; a good frame follows after one idle.
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hAA);
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, (i % 2 == 0) ? 8'hD5 : 8'h55);
    drive(1'b0, 1'b0, 8'h00);
    build_random(70, 1); send_frame(7, -1);

    // PHY error mid-payload on a good-FCS frame, then two good back-to-back.
    build_random(80, 1); send_frame(7, 30);
    build_random(66, 1); send_frame(7, -1);
    build_random(72, 1); send_frame(7, -1);

    // Randomized frames: length, FCS corruption, rx_er and preamble length.
    for (int f = 0; f < 30; f++) begin
      int n;
      int er_at;
      n     = int'($urandom_range(90, 1));
      er_at = ($urandom_range(7, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1;
      build_random(n, $urandom_range(3, 0) != 0);
      send_frame(int'($urandom_range(7, 1)), er_at);
    end

    // Reset during byte 20; only bytes visible before the reset are expected.
    build_random(60, 1);
    for (int k = 0; k < 14; k++) begin
      pay_t p;
      p.data = cur_frame[k];
      p.sof  = (k == 0);
      p.eof  = 1'b0;
      pay_q.push_back(p);
    end
    repeat (7) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, cur_frame[i]);
    @(posedge clk);
    #1;
    rx_dv   = 1'b1;
    rx_data = 8'hA0;
    rst     = 1'b1;
    #1;
    check_all_zero("async_reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) drive(1'b1, 1'b0, 8'hA0);
    drive(1'b0, 1'b0, 8'h00);
    build_random(64, 1); send_frame(7, -1);

    repeat (12) @(posedge clk);
    check("payload_queue_drained", 32'(pay_q.size()), 0);
    check("status_queue_drained", 32'(stat_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_rx_fcs_check.md
# eth_rx_fcs_check

Receive-side Ethernet 802.3 frame checker, the counterpart of the transmit-path CRC32 generator. It takes the byte stream from the PHY receive interface and locates the preamble and SFD. It runs the reflected CRC-32 over the frame, strips the 4-byte FCS, and forwards payload bytes to the downstream packet parser. At end of frame it reports good/bad status, including CRC and length checks.

## Interface
- MIN_LEN, 64: minimum legal frame length in bytes (DA through FCS inclusive).
- MAX_LEN, 1518: maximum legal frame length in bytes.
- clk  in  1  byte clock from PHY receive side.
- rst  in  1  asynchronous, active-high reset.
- rx_dv  in  1  receive data valid; one byte per clk while high.
- rx_er  in  1  PHY receive error.
- rx_data  in  8  receive byte.
- out_valid  out  1  out_data holds a payload byte.
- out_data  out  8  payload byte (FCS never forwarded).
- out_sof  out  1  with out_valid, marks the first payload byte.
- out_eof  out  1  with out_valid, marks the last payload byte.
- frame_done  out  1  one-cycle end-of-frame status strobe.
- frame_good  out  1  valid with frame_done: no crc_err, len_err or phy_err.
- crc_err  out  1  valid with frame_done: CRC residue mismatch.
- len_err  out  1  valid with frame_done: length < MIN_LEN or > MAX_LEN.
- phy_err  out  1  valid with frame_done: rx_er seen during the frame.
- frame_len  out  16  valid with frame_done: bytes after SFD, FCS included; saturates at 16'hFFFF.

## Operation
- States: IDLE, PREAMBLE, FRAME, DROP.
- IDLE:
  - rx_dv=1 and rx_data=8'h55 -> PREAMBLE.
  - rx_dv=1 with any other byte -> DROP.
- PREAMBLE:
  - 8'h55 -> stay.
  - 8'hD5 -> FRAME; clear CRC to 32'hFFFFFFFF, length to 0, and error flags.
  - Other byte -> DROP.
  - rx_dv=0 -> IDLE; no status emitted.
- FRAME:
  - Each byte with rx_dv=1 updates the CRC, increments the length (saturating), and is pushed into a 5-byte delay line.
  - rx_er=1 sets sticky phy_err.
  - rx_dv=0 ends the frame and returns to IDLE.
- DROP: wait for rx_dv=0, then IDLE. No outputs are produced.
- CRC:
  - Reflected polynomial 32'hEDB88320, LSB-first.
  - Nibble- or byte-wide table or XOR tree is acceptable.
  - The frame is good when the register after the last byte (FCS included) equals 32'hDEBB20E3.
- Delay line: byte k is emitted once byte k+5 has been accepted. At frame end, the byte still held at position 5 is frame byte N-5, the last payload byte. It is emitted with out_eof.
- out_sof goes on the first emitted byte of the frame.
- N ≤ 4: no payload bytes and no out_valid. frame_done is still pulsed, with len_err=1 and crc_err evaluated normally.
- N = 5: a single byte is emitted carrying both out_sof and out_eof.
- Bytes sampled with rx_dv=0 are ignored.

## Timing
- Reset values: all outputs 0, frame_len 0; state IDLE; delay line and CRC cleared.
- Payload latency: out_valid for byte k is high in the cycle after the edge that samples byte k+5.
- End of frame:
  - The first edge sampling rx_dv=0 in FRAME is edge e.
  - In the cycle after edge e: out_valid=1 and out_eof=1 for byte N-5 (if N ≥ 5), frame_done=1, and all status outputs are valid.
- All status outputs are 0 whenever frame_done=0.
- Back-to-back frames: one rx_dv=0 cycle between frames is sufficient. The next preamble byte may be sampled at edge e+1.
- out_valid is never high for two bytes of different frames in the same cycle.
- No backpressure: the consumer accepts every out_valid cycle.
- Reset mid-frame:
  - Outputs drop to 0 asynchronously.
  - No frame_done is emitted for the aborted frame.
  - After release with rx_dv still high on a non-0x55 byte, the block goes to DROP until rx_dv=0.

## Test plan
- Good frame, MIN_LEN=8: preamble 55×7, D5, then 31..39 ("123456789"), then 26 39 F4 CB. Required: 9 out bytes 31..39 with sof on 31 and eof on 39; frame_done with frame_good=1 and frame_len=13.
- Same frame with the last FCS byte changed to CA -> crc_err=1, frame_good=0; payload still forwarded.
- Default params, valid 63-byte frame with correct FCS -> len_err=1, crc_err=0. A valid 1519-byte frame -> len_err=1. Valid 64-byte and 1518-byte frames -> frame_good=1.
- Preamble 55 55 AA ... -> DROP; no out_valid and no frame_done until rx_dv falls. Next good frame after one idle cycle is checked correctly.
- rx_er pulsed once mid-payload on a good-FCS frame -> phy_err=1, frame_good=0. Two good frames with a one-cycle gap -> two frame_done pulses, both good.
- rst asserted for 2 cycles at byte 20 of a frame, with rx_dv held high after release -> all outputs 0 and no frame_done. After rx_dv falls, the following good frame passes with frame_good=1.
